ray_scene_scheduler: RTL and testbench

RAY_SCENE_SCHEDULER -- requirements
Module: ray_scene_scheduler

---
 rtl/ray_tracer_pkg.sv | 24 ++
 rtl/ray_scene_scheduler_if.sv | 13 +
 rtl/ray_dir_gen.sv | 57 +++++
 rtl/ray_scene_scheduler.sv | 146 ++++++++++++++
 tb/tb_ray_scene_scheduler.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ray_tracer_pkg.sv
// Shared field widths, field offsets, miss marker and FSM encoding for ray_scene_scheduler.
package ray_tracer_pkg;
   localparam int INIT_W        = 28;
   localparam int DIR_X_W       = 11;
   localparam int DIR_Y_W       = 11;
   localparam int DIR_Z_W       = 9;
   localparam int DIR_W         = DIR_X_W + DIR_Y_W + DIR_Z_W;
   localparam int OBJ_W         = 48;
   localparam int OBJ_CENTER_W  = 28;
   localparam int OBJ_R_LSB     = 28;
   localparam int OBJ_COLOR_LSB = 36;
   localparam int COLOR_W       = 12;
   localparam int T_W           = 10;
   localparam int ADDR_W        = 19;
   localparam logic [T_W-1:0] T_MISS = 10'h3FF;

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, COMPARE, EMIT} state_e;

   // Depth cue: every 4-bit channel dimmed by the top two bits of the hit distance.
   function automatic logic [COLOR_W-1:0] shade(input logic [COLOR_W-1:0] c,
                                                input logic [1:0] s);
      return {c[11:8] >> s, c[7:4] >> s, c[3:0] >> s};
   endfunction
endpackage

// File: rtl/ray_scene_scheduler_if.sv
// Pixel output stream of ray_scene_scheduler, with master (scheduler) and slave (sink) views.
interface ray_scene_scheduler_if;
   import ray_tracer_pkg::*;
   // pix_valid rises only with a complete pixel; pix_addr/pix_color hold until a cycle
   // with pix_valid && pix_ready, which is the single transfer point. pix_ready may toggle freely.
   logic               pix_valid;
   logic               pix_ready;
   logic [ADDR_W-1:0]  pix_addr;
   logic [COLOR_W-1:0] pix_color;

   modport master (output pix_valid, pix_addr, pix_color, input pix_ready);
   modport slave  (input pix_valid, pix_addr, pix_color, output pix_ready);
endinterface

// File: rtl/ray_dir_gen.sv
// Raster position tracking for ray_scene_scheduler: col/row counters, linear pixel address
// and the per-pixel primary ray direction.
module ray_dir_gen
   import ray_tracer_pkg::*;
#(
   parameter int         H_RES = 640,
   parameter int         V_RES = 480,
   parameter logic [8:0] FOCAL = 9'd200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   output logic [ADDR_W-1:0] pix_addr,
   output logic [DIR_W-1:0]  dir,
   output logic              last
);
   logic [10:0]       col_q, col_d, row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              col_end;

   // Pixels are visited in raster order, so row*H_RES+col is just a running count.
   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      col_end = (col_q == 11'(H_RES - 1));
      last    = col_end && (row_q == 11'(V_RES - 1));
      if (clear) begin
         col_d  = '0;
         row_d  = '0;
         addr_d = '0;
      end else if (advance) begin
         addr_d = addr_q + 19'd1;
         if (col_end) begin
            col_d = '0;
            row_d = row_q + 11'd1;
         end else begin
            col_d = col_q + 11'd1;
         end
      end
      dir      = {col_q - 11'(H_RES / 2), 11'(V_RES / 2) - row_q, FOCAL};
      pix_addr = addr_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         addr_q <= addr_d;
      end
   end
endmodule

// File: rtl/ray_scene_scheduler.sv
// Frame scheduler: per pixel, issues one tracer job per scene object, keeps the nearest hit
// and streams the pixel colour out. Optional macro SCHED_DEPTH_SHADE_EN dims hits by distance.
module ray_scene_scheduler
   import ray_tracer_pkg::*;
#(
   parameter int          H_RES         = 640,
   parameter int          V_RES         = 480,
   parameter int          NUM_OBJ       = 8,
   parameter logic [8:0]  FOCAL         = 9'd200,
   parameter int          TRACE_LATENCY = 52,
   parameter logic [11:0] BG_COLOR      = 12'h000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [INIT_W-1:0]  cam_pos,
   output logic [7:0]         obj_addr,
   input  logic [OBJ_W-1:0]   obj_data,
   output logic [INIT_W-1:0]  ray_init,
   output logic [DIR_W-1:0]   ray_dir,
   output logic [OBJ_W-1:0]   obj_out,
   input  logic [T_W-1:0]     t_in,
   ray_scene_scheduler_if.master pix,
   output logic               busy,
   output logic               done,
   output state_e             state_dbg
);
   state_e             state_q, state_d;
   logic [7:0]         obj_idx_q, obj_idx_d;
   logic [INIT_W-1:0]  cam_q, cam_d, ray_init_q, ray_init_d;
   logic [DIR_W-1:0]   ray_dir_q, ray_dir_d, gen_dir;
   logic [OBJ_W-1:0]   obj_out_q, obj_out_d;
   logic [15:0]        wait_q, wait_d;
   logic [T_W-1:0]     t_q, t_d, min_t_q, min_t_d;
   logic [COLOR_W-1:0] min_color_q, min_color_d, hit_color;
   logic               done_q, done_d;
   logic               hs, gen_clear, gen_last;

   ray_dir_gen #(.H_RES(H_RES), .V_RES(V_RES), .FOCAL(FOCAL)) u_dir_gen (
      .clk(clk), .rst(rst), .clear(gen_clear), .advance(hs),
      .pix_addr(pix.pix_addr), .dir(gen_dir), .last(gen_last)
   );

   always_comb begin
      state_d     = state_q;
      obj_idx_d   = obj_idx_q;
      cam_d       = cam_q;
      ray_init_d  = ray_init_q;
      ray_dir_d   = ray_dir_q;
      obj_out_d   = obj_out_q;
      wait_d      = wait_q;
      t_d         = t_q;
      min_t_d     = min_t_q;
      min_color_d = min_color_q;
      done_d      = 1'b0;
      hs          = (state_q == EMIT) && pix.pix_ready;
      gen_clear   = (state_q == IDLE) && start;
      case (state_q)
         IDLE: if (start) begin
            cam_d     = cam_pos;
            obj_idx_d = '0;
            min_t_d   = T_MISS;
            state_d   = FETCH;
         end
         FETCH: state_d = ISSUE;
         ISSUE: begin
            obj_out_d  = obj_data;
            ray_init_d = cam_q;
            ray_dir_d  = gen_dir;
            wait_d     = '0;
            state_d    = WAIT;
         end
         WAIT: if (wait_q == 16'(TRACE_LATENCY - 1)) begin
            t_d     = t_in;
            state_d = COMPARE;
         end else begin
            wait_d = wait_q + 16'd1;
         end
         COMPARE: begin
            // Strict less-than: on equal distance the earlier object stays the winner.
            if (t_q != T_MISS && t_q < min_t_q) begin
               min_t_d     = t_q;
               min_color_d = obj_out_q[OBJ_COLOR_LSB +: COLOR_W];
            end
            if (obj_idx_q < 8'(NUM_OBJ - 1)) begin
               obj_idx_d = obj_idx_q + 8'd1;
               state_d   = FETCH;
            end else begin
               state_d = EMIT;
            end
         end
         EMIT: if (pix.pix_ready) begin
            obj_idx_d = '0;
            min_t_d   = T_MISS;
            done_d    = gen_last;
            state_d   = gen_last ? IDLE : FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
`ifdef SCHED_DEPTH_SHADE_EN
      hit_color = shade(min_color_q, min_t_q[9:8]);
`else
      hit_color = min_color_q;
`endif
      pix.pix_valid = (state_q == EMIT);
      pix.pix_color = (state_q != EMIT) ? '0 : (min_t_q == T_MISS) ? BG_COLOR : hit_color;
      obj_addr      = obj_idx_q;
      ray_init      = ray_init_q;
      ray_dir       = ray_dir_q;
      obj_out       = obj_out_q;
      busy          = (state_q != IDLE);
      done          = done_q;
      state_dbg     = state_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         obj_idx_q   <= '0;
         cam_q       <= '0;
         ray_init_q  <= '0;
         ray_dir_q   <= '0;
         obj_out_q   <= '0;
         wait_q      <= '0;
         t_q         <= T_MISS;
         min_t_q     <= T_MISS;
         min_color_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         obj_idx_q   <= obj_idx_d;
         cam_q       <= cam_d;
         ray_init_q  <= ray_init_d;
         ray_dir_q   <= ray_dir_d;
         obj_out_q   <= obj_out_d;
         wait_q      <= wait_d;
         t_q         <= t_d;
         min_t_q     <= min_t_d;
         min_color_q <= min_color_d;
         done_q      <= done_d;
      end
   end
endmodule

// File: tb/tb_ray_scene_scheduler.sv
// Scoreboard bench for ray_scene_scheduler: small-frame instance against a frame-level
// reference model, plus a full-size instance for first-ray direction and busy-start checks.
module tb_ray_scene_scheduler;
   import ray_tracer_pkg::*;
   localparam int          H   = 4;
   localparam int          V   = 3;
   localparam int          N   = 3;
   localparam int          L   = 5;
   localparam logic [8:0]  FOC = 9'd37;
   localparam logic [11:0] BG  = 12'h5A5;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, ready = 1'b0;
   logic [27:0] cam_pos = '0;
   logic [7:0]  obj_addr;
   logic [47:0] obj_data = '0;
   logic [27:0] ray_init;
   logic [30:0] ray_dir;
   logic [47:0] obj_out;
   logic [9:0]  t_in = 10'h3FF;
   logic        busy, done;
   state_e      state_dbg;

   logic        start_hd = 1'b0;
   logic [27:0] cam_hd = '0;
   logic [7:0]  obj_addr_hd;
   logic [27:0] ray_init_hd;
   logic [30:0] ray_dir_hd;
   logic [47:0] obj_out_hd;
   logic        busy_hd, done_hd;
   state_e      state_hd;

   ray_scene_scheduler_if pix();
   ray_scene_scheduler_if pix_hd();
   assign pix.pix_ready    = ready;
   assign pix_hd.pix_ready = 1'b0;

   ray_scene_scheduler #(.H_RES(H), .V_RES(V), .NUM_OBJ(N), .FOCAL(FOC),
                         .TRACE_LATENCY(L), .BG_COLOR(BG)) dut (
      .clk(clk), .rst(rst), .start(start), .cam_pos(cam_pos), .obj_addr(obj_addr),
      .obj_data(obj_data), .ray_init(ray_init), .ray_dir(ray_dir), .obj_out(obj_out),
      .t_in(t_in), .pix(pix.master), .busy(busy), .done(done), .state_dbg(state_dbg));

   ray_scene_scheduler dut_hd (
      .clk(clk), .rst(rst), .start(start_hd), .cam_pos(cam_hd), .obj_addr(obj_addr_hd),
      .obj_data(48'h0), .ray_init(ray_init_hd), .ray_dir(ray_dir_hd), .obj_out(obj_out_hd),
      .t_in(10'h3FF), .pix(pix_hd.master), .busy(busy_hd), .done(done_hd), .state_dbg(state_hd));

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- environment models ----------------
   logic [47:0] rom [N];
   int mode = 0;        // 0: hashed hits, 1: all miss, 2: t = low 10 bits of object word
   int ready_mode = 0;  // 0: random, 1: always ready, 2: held low
   int cd = -1;

   always @(posedge clk) obj_data <= (obj_addr < 8'(N)) ? rom[obj_addr] : 48'h0;

   function automatic logic [9:0] trace_t(input logic [47:0] obj, input logic [30:0] dir,
                                          input logic [27:0] org);
      logic [31:0] h;
      if (mode == 1) return 10'h3FF;
      if (mode == 2) return obj[9:0];
      h = (({1'b0, dir} ^ {4'h0, org}) * 32'h9E3779B1) ^ {4'h0, obj[27:0]};
      h = h ^ (h >> 15);
      h = h * 32'h85EBCA6B;
      h = h ^ (h >> 13);
      if (h[1:0] == 2'b00) return 10'h3FF;
      return {h[20:18], 7'h10};
   endfunction

   // Tracer: the real answer appears exactly TRACE_LATENCY cycles after the issue cycle.
   always begin
      @(posedge clk); #1;
      if (!rst) cd = -1;
      else if (state_dbg == ISSUE) cd = L;
      else if (cd >= 0) cd--;
      t_in = (cd == 0) ? trace_t(obj_out, ray_dir, ray_init) : 10'($urandom);
   end

   always begin
      @(posedge clk); #1;
      case (ready_mode)
         0:       ready = ($urandom_range(0, 3) != 0);
         1:       ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // ---------------- scoreboard ----------------
   logic [30:0] exp_q[$];
   int compared = 0, mismatched = 0;
   int hs_cnt = 0, done_cnt = 0, frame_hs0 = 0, frame_done0 = 0;
   bit stall = 0;
   logic [18:0] held_addr;
   logic [11:0] held_color;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [27:0] cam);
      for (int p = 0; p < H * V; p++) begin
         int          col, row;
         logic [30:0] dir;
         logic [9:0]  best_t, t;
         logic [11:0] c;
         col    = p % H;
         row    = p / H;
         dir    = {11'(col - H / 2), 11'(V / 2 - row), FOC};
         best_t = 10'h3FF;
         c      = BG;
         for (int o = 0; o < N; o++) begin
            t = trace_t(rom[o], dir, cam);
            if (t != 10'h3FF && t < best_t) begin
               best_t = t;
               c      = rom[o][47:36];
            end
         end
`ifdef SCHED_DEPTH_SHADE_EN
         if (best_t != 10'h3FF) c = {c[11:8] >> best_t[9:8], c[7:4] >> best_t[9:8], c[3:0] >> best_t[9:8]};
`endif
         exp_q.push_back({19'(p), c});
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         stall = 0;
      end else begin
         if (stall) check("hold", {pix.pix_valid, pix.pix_addr, pix.pix_color}, {1'b1, held_addr, held_color});
         if (pix.pix_valid && pix.pix_ready) begin
            logic [30:0] e;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 31'h7FFFFFFF;
            check("pixel", {pix.pix_addr, pix.pix_color}, e);
            hs_cnt++;
            stall = 0;
         end else if (pix.pix_valid) begin
            stall      = 1;
            held_addr  = pix.pix_addr;
            held_color = pix.pix_color;
         end else begin
            stall = 0;
         end
         if (done) done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   bit spurious_en = 0;

   task automatic load_rom_random();
      for (int o = 0; o < N; o++) rom[o] = 48'({$urandom(), $urandom()});
   endtask

   task automatic start_frame(input logic [27:0] cam);
      frame_hs0   = hs_cnt;
      frame_done0 = done_cnt;
      push_frame(cam);
      @(posedge clk); #1;
      cam_pos = cam;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      cam_pos = 28'($urandom);
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_frame(input string tag);
      int cyc = 0;
      while (done_cnt == frame_done0 && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
         if (spurious_en && busy && $urandom_range(0, 15) == 0) begin
            start   = 1'b1;
            cam_pos = 28'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_once"}, done_cnt - frame_done0, 1);
      check({tag, "_pixels"}, hs_cnt - frame_hs0, H * V);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      logic [27:0] cam0;
      load_rom_random();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", pix.pix_valid, 0);
      check("rst_addr", pix.pix_addr, 0);
      check("rst_color", pix.pix_color, 0);
      check("rst_outs", {obj_addr, ray_init, ray_dir, obj_out}, 0);
      @(negedge clk) rst = 1'b1;

      // Full-size instance: first ray of the frame, then a start while busy.
      @(posedge clk); #1;
      cam0 = 28'h1234567;
      cam_hd = cam0; start_hd = 1'b1;
      @(posedge clk); #1;
      start_hd = 1'b0;
      cyc = 0;
      while (state_hd != WAIT && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("hd_reach_wait", state_hd == WAIT, 1);
      check("hd_dir_px0", ray_dir_hd, {11'h6C0, 11'd240, 9'd200});
      check("hd_init", ray_init_hd, cam0);
      cam_hd = 28'h0ABCDEF; start_hd = 1'b1;
      @(posedge clk); #1;
      start_hd = 1'b0;
      cyc = 0;
      while (!(obj_addr_hd == 8'd1 && state_hd == WAIT) && cyc < 200) begin @(posedge clk); #1; cyc++; end
      check("hd_second_job", obj_addr_hd, 1);
      check("hd_init_kept", ray_init_hd, cam0);
      check("hd_busy", busy_hd, 1);

      // Frame 1: random objects and hits, random backpressure, starts while busy.
      mode = 0; ready_mode = 0; spurious_en = 1;
      start_frame(28'($urandom));
      wait_frame("f1");

      // Frame 2: every ray misses, always ready.
      mode = 1; ready_mode = 1; spurious_en = 0;
      start_frame(28'($urandom));
      wait_frame("f2");

      // Frame 3: t = {40,20,20}, colours {F00,0F0,00F}; tie keeps object 1. Stall 10 cycles.
      mode = 2; ready_mode = 2;
      rom[0] = {12'hF00, 8'h11, 28'h0000040};
      rom[1] = {12'h0F0, 8'h22, 28'h0000020};
      rom[2] = {12'h00F, 8'h33, 28'h0000020};
      start_frame(28'($urandom));
      cyc = 0;
      while (!pix.pix_valid && cyc < 500) begin @(posedge clk); #1; cyc++; end
      check("f3_valid", pix.pix_valid, 1);
      repeat (10) @(posedge clk);
      #1;
      check("f3_stalled_valid", pix.pix_valid, 1);
      check("f3_stalled_addr", pix.pix_addr, 0);
      check("f3_stalled_hs", hs_cnt - frame_hs0, 0);
      check("f3_color", pix.pix_color, 12'h0F0);
      ready_mode = 1;
      wait_frame("f3");

      // Frame 4: reset in the WAIT of pixel 5, then a clean restart from address 0.
      mode = 0; ready_mode = 0;
      load_rom_random();
      start_frame(28'($urandom));
      cyc = 0;
      while (!(hs_cnt - frame_hs0 == 5 && state_dbg == WAIT) && cyc < 2000) begin @(posedge clk); #1; cyc++; end
      check("f4_reach_px5", hs_cnt - frame_hs0, 5);
      @(negedge clk) rst = 1'b0;
      #1;
      check("f4_rst_busy", busy, 0);
      check("f4_rst_valid", pix.pix_valid, 0);
      check("f4_rst_addr", pix.pix_addr, 0);
      check("f4_rst_outs", {obj_addr, ray_init, ray_dir, obj_out}, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      start_frame(28'($urandom));
      wait_frame("f5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
